// File: rtl/regfile_fetch_pkg.sv
// Shared types and default widths for the register-file operand fetch block.
// Holds the sequencer state enum and the default data/address/tag widths.
package regfile_fetch_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 3;
    localparam int DEF_TAG_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        CAPTURE,
        HOLD
    } fetch_state_t;

endpackage

// File: rtl/regfile_operand_fetch_bypass.sv
// operand_bypass_mux: picks the freshest value for one source operand.
// Ports: rf_data (file output), byp_flag/byp_value (writeback saved in READ),
//        wb_valid/wb_addr/wb_data (live writeback), src_addr, operand (result).
module operand_bypass_mux
    import regfile_fetch_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic [DATA_W-1:0] rf_data,
    input  logic              byp_flag,
    input  logic [DATA_W-1:0] byp_value,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] src_addr,
    output logic [DATA_W-1:0] operand
);

    logic live_hit;

    // A live writeback is younger than anything saved in READ, so it wins.
    assign live_hit = wb_valid && (wb_addr == src_addr);

    always_comb begin
        operand = rf_data;
        if (live_hit) begin
            operand = wb_data;
        end else if (byp_flag) begin
            operand = byp_value;
        end
    end

endmodule

// File: rtl/regfile_operand_fetch.sv
// Operand fetch sequencer: drives an 8x16 register file with 1-cycle reads,
// forwards writebacks the read timing would miss, and hands operands onward.
// Ports: CLK, RST_N; req_* (request in, valid/ready); wb_* (writeback in);
//        rf_* (register file read/write ports); op_* (operands out, valid/ready).
module regfile_operand_fetch
    import regfile_fetch_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int TAG_W  = DEF_TAG_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_rs_a,
    input  logic [ADDR_W-1:0] req_rs_b,
    input  logic [ADDR_W-1:0] req_rd,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] rf_readA_addr,
    output logic [ADDR_W-1:0] rf_readB_addr,
    input  logic [DATA_W-1:0] rf_A,
    input  logic [DATA_W-1:0] rf_B,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_value,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [ADDR_W-1:0] op_rd,
    output logic [TAG_W-1:0]  op_tag
);

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic         load_req;

    logic [ADDR_W-1:0] rs_a_q;
    logic [ADDR_W-1:0] rs_b_q;
    logic [ADDR_W-1:0] rd_q;
    logic [TAG_W-1:0]  tag_q;

    logic              byp_a_q;
    logic              byp_b_q;
    logic [DATA_W-1:0] saved_a_q;
    logic [DATA_W-1:0] saved_b_q;

    logic              hit_a;
    logic              hit_b;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;

    // Writeback is never stalled; it feeds the file directly.
    assign rf_write       = wb_valid;
    assign rf_write_addr  = wb_addr;
    assign rf_write_value = wb_data;

    assign rf_readA_addr = rs_a_q;
    assign rf_readB_addr = rs_b_q;

    assign hit_a = wb_valid && (wb_addr == rs_a_q);
    assign hit_b = wb_valid && (wb_addr == rs_b_q);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        load_req  = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    load_req = 1'b1;
                    state_d  = READ;
                end
            end
            READ: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                state_d = HOLD;
            end
            HOLD: begin
                req_ready = op_ready;
                if (op_ready) begin
                    if (req_valid) begin
                        load_req = 1'b1;
                        state_d  = READ;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rs_a_q <= '0;
            rs_b_q <= '0;
            rd_q   <= '0;
            tag_q  <= '0;
        end else if (load_req) begin
            rs_a_q <= req_rs_a;
            rs_b_q <= req_rs_b;
            rd_q   <= req_rd;
            tag_q  <= req_tag;
        end
    end

    // A write landing on the READ edge is missed by the file's sample,
    // so it is saved here and replayed at CAPTURE.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            byp_a_q   <= 1'b0;
            byp_b_q   <= 1'b0;
            saved_a_q <= '0;
            saved_b_q <= '0;
        end else if (state_q == READ) begin
            byp_a_q <= hit_a;
            byp_b_q <= hit_b;
            if (hit_a) begin
                saved_a_q <= wb_data;
            end
            if (hit_b) begin
                saved_b_q <= wb_data;
            end
        end else if (state_q == CAPTURE) begin
            byp_a_q <= 1'b0;
            byp_b_q <= 1'b0;
        end
    end

    operand_bypass_mux #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_mux_a (
        .rf_data  (rf_A),
        .byp_flag (byp_a_q),
        .byp_value(saved_a_q),
        .wb_valid (wb_valid),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .src_addr (rs_a_q),
        .operand  (fwd_a)
    );

    operand_bypass_mux #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_mux_b (
        .rf_data  (rf_B),
        .byp_flag (byp_b_q),
        .byp_value(saved_b_q),
        .wb_valid (wb_valid),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .src_addr (rs_b_q),
        .operand  (fwd_b)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            op_valid <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            op_rd    <= '0;
            op_tag   <= '0;
        end else if (state_q == CAPTURE) begin
            op_valid <= 1'b1;
            op_a     <= fwd_a;
            op_b     <= fwd_b;
            op_rd    <= rd_q;
            op_tag   <= tag_q;
        end else if (state_q == HOLD && op_ready) begin
            op_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Bench for regfile_operand_fetch paired with an 8x16 register file model.
// Operand expectations come from a register-value model at capture time.
module tb_regfile_operand_fetch;

    logic        CLK;
    logic        RST_N;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_rs_a;
    logic [2:0]  req_rs_b;
    logic [2:0]  req_rd;
    logic [3:0]  req_tag;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic [2:0]  rf_readA_addr;
    logic [2:0]  rf_readB_addr;
    logic [15:0] rf_A;
    logic [15:0] rf_B;
    logic        rf_write;
    logic [2:0]  rf_write_addr;
    logic [15:0] rf_write_value;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [2:0]  op_rd;
    logic [3:0]  op_tag;

    int checks = 0;
    int errors = 0;

    logic [15:0] rf_mem  [8];
    logic [15:0] ref_mem [8];

    regfile_operand_fetch dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_rs_a      (req_rs_a),
        .req_rs_b      (req_rs_b),
        .req_rd        (req_rd),
        .req_tag       (req_tag),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .rf_readA_addr (rf_readA_addr),
        .rf_readB_addr (rf_readB_addr),
        .rf_A          (rf_A),
        .rf_B          (rf_B),
        .rf_write      (rf_write),
        .rf_write_addr (rf_write_addr),
        .rf_write_value(rf_write_value),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .op_a          (op_a),
        .op_b          (op_b),
        .op_rd         (op_rd),
        .op_tag        (op_tag)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Register file: registered reads, write on the same edge (old data read).
    always @(posedge CLK) begin
        if (rf_write) rf_mem[rf_write_addr] <= rf_write_value;
        rf_A <= rf_mem[rf_readA_addr];
        rf_B <= rf_mem[rf_readB_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Every writeback issued on an edge updates the reference register values.
    task automatic tick();
        @(posedge CLK);
        if (wb_valid) ref_mem[wb_addr] = wb_data;
        #1;
    endtask

    task automatic set_wb(input logic v, input logic [2:0] a,
                          input logic [15:0] d);
        wb_valid = v;
        wb_addr  = a;
        wb_data  = d;
    endtask

    task automatic issue(input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] rd, input logic [3:0] tg);
        req_valid = 1'b1;
        req_rs_a  = a;
        req_rs_b  = b;
        req_rd    = rd;
        req_tag   = tg;
        op_ready  = 1'b1;
        #1;
        chk("accept_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
    endtask

    // Walk READ and CAPTURE with the given writebacks, then check operands
    // against register values as they stand after the CAPTURE edge.
    task automatic finish_op(input logic [2:0] a, input logic [2:0] b,
                             input logic [2:0] rd, input logic [3:0] tg,
                             input logic rv, input logic [2:0] ra,
                             input logic [15:0] rdat,
                             input logic cv, input logic [2:0] ca,
                             input logic [15:0] cdat,
                             output logic [15:0] ea, output logic [15:0] eb);
        set_wb(rv, ra, rdat);
        #1;
        chk("read_op_valid", op_valid, 0);
        chk("read_ready", req_ready, 0);
        chk("read_addr_a", rf_readA_addr, a);
        chk("read_addr_b", rf_readB_addr, b);
        tick();
        set_wb(cv, ca, cdat);
        #1;
        chk("cap_op_valid", op_valid, 0);
        tick();
        set_wb(1'b0, 3'd0, 16'h0);
        ea = ref_mem[a];
        eb = ref_mem[b];
        #1;
        chk("op_valid", op_valid, 1);
        chk("op_a", op_a, ea);
        chk("op_b", op_b, eb);
        chk("op_rd", op_rd, rd);
        chk("op_tag", op_tag, tg);
    endtask

    logic [15:0] ea, eb;

    initial begin
        RST_N     = 1'b0;
        req_valid = 1'b0;
        req_rs_a  = '0;
        req_rs_b  = '0;
        req_rd    = '0;
        req_tag   = '0;
        op_ready  = 1'b0;
        set_wb(1'b0, 3'd0, 16'h0);
        #2;
        chk("rst_op_valid", op_valid, 0);
        chk("rst_op_a", op_a, 0);
        chk("rst_op_tag", op_tag, 0);
        chk("rst_addr_a", rf_readA_addr, 0);
        chk("rst_addr_b", rf_readB_addr, 0);
        chk("rst_req_ready", req_ready, 1);

        // Preload through the writeback path while still in reset.
        for (int r = 0; r < 8; r++) begin
            logic [15:0] v;
            v = (r == 2) ? 16'h1234 : (r == 5) ? 16'hBEEF : 16'(r * 16'h0101);
            set_wb(1'b1, 3'(r), v);
            #1;
            chk("wb_pass_en", rf_write, 1);
            chk("wb_pass_addr", rf_write_addr, r);
            chk("wb_pass_data", rf_write_value, v);
            tick();
        end
        set_wb(1'b0, 3'd0, 16'h0);
        RST_N = 1'b1;
        tick();

        // Plain fetch, 3-edge latency.
        issue(3'd2, 3'd5, 3'd1, 4'd3);
        finish_op(3'd2, 3'd5, 3'd1, 4'd3, 0, 0, 0, 0, 0, 0, ea, eb);
        chk("basic_a", op_a, 16'h1234);
        chk("basic_b", op_b, 16'hBEEF);
        chk("basic_tag", op_tag, 4'd3);
        op_ready = 1'b1;
        tick();
        chk("release_valid", op_valid, 0);

        // Writeback during READ must be forwarded.
        issue(3'd2, 3'd0, 3'd2, 4'd4);
        finish_op(3'd2, 3'd0, 3'd2, 4'd4, 1, 3'd2, 16'h5555, 0, 0, 0, ea, eb);
        chk("readfwd_a", op_a, 16'h5555);

        // Same register written in READ and CAPTURE: CAPTURE value wins.
        issue(3'd4, 3'd4, 3'd3, 4'd5);
        finish_op(3'd4, 3'd4, 3'd3, 4'd5, 1, 3'd4, 16'h0001,
                  1, 3'd4, 16'h0002, ea, eb);
        chk("dbl_a", op_a, 16'h0002);
        chk("dbl_b", op_b, 16'h0002);

        // Backpressure: HOLD writes must not disturb held operands.
        issue(3'd2, 3'd5, 3'd6, 4'd7);
        finish_op(3'd2, 3'd5, 3'd6, 4'd7, 0, 0, 0, 0, 0, 0, ea, eb);
        op_ready = 1'b0;
        set_wb(1'b1, 3'd2, 16'h7777);
        #1;
        chk("hold_ready", req_ready, 0);
        for (int c = 0; c < 5; c++) begin
            tick();
            set_wb(1'b0, 3'd0, 16'h0);
            chk("hold_valid", op_valid, 1);
            chk("hold_a", op_a, 16'h5555);
        end
        issue(3'd2, 3'd2, 3'd1, 4'd8);
        finish_op(3'd2, 3'd2, 3'd1, 4'd8, 0, 0, 0, 0, 0, 0, ea, eb);
        chk("b2b_a", op_a, 16'h7777);

        // Reset in CAPTURE drops the request.
        op_ready = 1'b1;
        tick();
        issue(3'd5, 3'd2, 3'd3, 4'd9);
        tick();
        RST_N = 1'b0;
        #1;
        chk("mid_rst_valid", op_valid, 0);
        chk("mid_rst_a", op_a, 0);
        chk("mid_rst_b", op_b, 0);
        chk("mid_rst_rd", op_rd, 0);
        chk("mid_rst_tag", op_tag, 0);
        chk("mid_rst_addr_a", rf_readA_addr, 0);
        tick();
        RST_N = 1'b1;
        #1;
        chk("post_rst_ready", req_ready, 1);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("dropped_valid", op_valid, 0);
        end

        // Randomized traffic against the register-value model.
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  a, b, rd;
            logic [3:0]  tg;
            logic [15:0] ha, hb;
            a  = 3'($urandom_range(0, 7));
            b  = 3'($urandom_range(0, 7));
            rd = 3'($urandom_range(0, 7));
            tg = 4'($urandom_range(0, 15));
            set_wb(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   16'($urandom));
            issue(a, b, rd, tg);
            finish_op(a, b, rd, tg,
                      1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      16'($urandom),
                      1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      16'($urandom), ha, hb);
            op_ready = 1'b0;
            for (int c = 0; c < int'($urandom_range(0, 3)); c++) begin
                set_wb(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                       16'($urandom));
                tick();
                chk("rnd_hold_valid", op_valid, 1);
                chk("rnd_hold_a", op_a, ha);
                chk("rnd_hold_b", op_b, hb);
            end
            set_wb(1'b0, 3'd0, 16'h0);
            if ($urandom_range(0, 1) == 0) begin
                op_ready = 1'b1;
                tick();
                chk("rnd_release", op_valid, 0);
            end
        end
        op_ready = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_operand_fetch.md
Name: regfile_operand_fetch

Overview:
- Client-side sequencer for the 8x16 register file: it drives the two read ports and the write port.
- Accepts decoded operand requests (rs_a, rs_b, rd, tag) and absorbs the file's 1-cycle registered read latency.
- Forwards any writeback that the file's read timing would otherwise miss, then presents coherent operands to the ALU stage with a valid/ready handshake.
- The writeback channel from the execute stage passes through to the file's write port.

Parameters:
- DATA_W, 16, register/operand width
- ADDR_W, 3, register address width (8 registers)
- TAG_W, 4, opaque request tag carried through to the operand output

Ports:
- CLK  in  1  clock; all state changes on the rising edge
- RST_N  in  1  asynchronous active-low reset
- req_valid  in  1  operand request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_rs_a  in  ADDR_W  source register A
- req_rs_b  in  ADDR_W  source register B
- req_rd  in  ADDR_W  destination register, carried through
- req_tag  in  TAG_W  carried through
- wb_valid  in  1  writeback request
- wb_addr  in  ADDR_W  writeback register
- wb_data  in  DATA_W  writeback value
- rf_readA_addr  out  ADDR_W  to register file read port A
- rf_readB_addr  out  ADDR_W  to register file read port B
- rf_A  in  DATA_W  register file output A (registered, 1-cycle latency)
- rf_B  in  DATA_W  register file output B
- rf_write  out  1  register file write enable
- rf_write_addr  out  ADDR_W  register file write address
- rf_write_value  out  DATA_W  register file write data
- op_valid  out  1  operands valid
- op_ready  in  1  consumer accepts when op_valid && op_ready
- op_a  out  DATA_W  operand A
- op_b  out  DATA_W  operand B
- op_rd  out  ADDR_W  carried destination register
- op_tag  out  TAG_W  carried tag

Behaviour:
- Reset (RST_N low, asynchronous):
  - state=IDLE
  - op_valid=0; op_a, op_b, op_rd, op_tag = 0
  - latched rs_a, rs_b, rd, tag = 0, so rf_readA_addr and rf_readB_addr = 0
  - bypass flags cleared
- Writeback path:
  - rf_write=wb_valid, rf_write_addr=wb_addr, rf_write_value=wb_data, combinational pass-through.
  - Writeback is always accepted (no wb_ready); it is active in every state, including during reset.
- Read address outputs are registered copies of the latched request fields.
- States:
  - IDLE: req_ready=1. On accept, latch request fields and go to READ.
  - READ: the register file samples addresses at the end of this cycle. If wb_valid && wb_addr==rs_a, set byp_a and save wb_data; same rule for rs_b. Go to CAPTURE.
  - CAPTURE: rf_A/rf_B are valid. At the edge, op_a := (wb_valid && wb_addr==rs_a) ? wb_data : byp_a ? saved_a : rf_A; same rule for op_b. Copy rd and tag, set op_valid=1, clear bypass flags, go to HOLD.
  - HOLD: op_valid=1 and outputs stable. req_ready=op_ready.
    - op_ready && req_valid: latch the new request, go to READ; op_valid falls.
    - op_ready && !req_valid: go to IDLE; op_valid=0.
    - !op_ready: stay.
- Coherence rule: operands reflect every writeback issued up to and including the CAPTURE cycle. Writebacks during HOLD do not alter held operands.
- Latency and throughput: request accept to op_valid is 3 edges. Sustained throughput is 1 request per 3 cycles.
- Boundary cases:
  - rs_a==rs_b: both operands get an identical forwarded value.
  - Writebacks in both READ and CAPTURE to the same address: the CAPTURE value wins.
  - Writeback in the accept cycle needs no bypass; the file already holds the value at the READ sample.
  - Reset mid-operation: the in-flight request is dropped and no op_valid is produced.

Decomposition:
- Package regfile_fetch_pkg: state enum (IDLE, READ, CAPTURE, HOLD), default widths.
- One sub-module, operand_bypass_mux, instantiated twice: inputs are rf data, the saved bypass value/flag, live wb_*, and the source address; output is the operand.

Test Plan:
- The bench pairs the block with the 8x16 register file: 1-cycle registered reads, write on the same edge.
- Preload: R2=0x1234, R5=0xBEEF. Request rs_a=2, rs_b=5, tag=3 -> op_valid on the 3rd edge with op_a=0x1234, op_b=0xBEEF, op_tag=3.
- READ-cycle forward: request rs_a=2, with wb R2=0x5555 during READ -> op_a=0x5555 (without the bypass the file would return 0x1234).
- Same-register double forward: wb R4=0x0001 in READ and wb R4=0x0002 in CAPTURE, request rs_a=rs_b=4 -> op_a=op_b=0x0002.
- Backpressure and back-to-back:
  - Hold op_ready=0 for 5 cycles and write R2=0x7777 during HOLD -> op_a stays at its captured value and op_valid holds.
  - Then op_ready=1 with a new request -> next op_valid 3 cycles later and op_a=0x7777.
- Reset mid-operation: assert RST_N low in CAPTURE -> op_valid=0 and all outputs 0 immediately; the dropped request never appears; req_ready=1 after release.
